// File: rtl/rb_window_former.sv
// rtl/rb_window_former.sv - row-buffer column reorder and sliding WIN_SIZE x WIN_SIZE window former
// Optional feature macro: BORDER_REPLICATE_EN (edge-column replication with a FLUSH state)
module rb_window_former #(
  parameter int IMAGE_WIDTH = 512,
  parameter int RB_COUNT    = 4,
  parameter int WIN_SIZE    = 3,
  parameter int PIXEL_W     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [RB_COUNT*PIXEL_W-1:0]           in_col,
  input  logic [$clog2(RB_COUNT)-1:0]           in_rot,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]        in_col_addr,
  input  logic                                  in_line_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIN_SIZE*WIN_SIZE*PIXEL_W-1:0]  out_window,
  output logic [$clog2(IMAGE_WIDTH)-1:0]        out_col,
  output logic                                  out_line_end,
  output logic                                  out_frame_end,
  output logic                                  frame_done,
  output logic                                  col_error
);

  localparam int AW   = $clog2(IMAGE_WIDTH);
  localparam int CW   = $clog2(WIN_SIZE);
  localparam int COLW = WIN_SIZE * PIXEL_W;
  localparam int WINW = WIN_SIZE * COLW;
  localparam int HALF = (WIN_SIZE - 1) / 2;
`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
`else
  localparam bit BORDER = 1'b0;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
`endif

  state_t                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [AW-1:0]                prev_q;
  logic                         col_error_q;
  logic                         s1_vld_q, s1_emit_q, s1_restart_q, s1_end_q, s1_last_q;
  logic [COLW-1:0]              s1_col_q;
  logic [AW-1:0]                s1_ocol_q;
`ifdef BORDER_REPLICATE_EN
  logic [CW-1:0]                fc_q;
`endif
  logic [WIN_SIZE-1:0][COLW-1:0] win_q, win_d;
  logic [WINW-1:0]              win_flat;
  logic [COLW-1:0]              col_ord;
  logic                         out_valid_q, out_line_end_q, out_frame_end_q;
  logic [WINW-1:0]              out_window_q;
  logic [AW-1:0]                out_col_q;
  logic                         adv, accept;

  assign adv = !out_valid_q || out_ready;
`ifdef BORDER_REPLICATE_EN
  assign in_ready = rst && adv && (state_q != FLUSH);
`else
  assign in_ready = rst && adv;
`endif
  assign accept = in_valid && in_ready;

  // Row r of the window comes from buffer (in_rot + r) mod RB_COUNT, oldest line first
  always_comb begin
    int idx;
    col_ord = '0;
    idx     = 0;
    for (int r = 0; r < WIN_SIZE; r++) begin
      idx = (int'(in_rot) + r) % RB_COUNT;
      col_ord[r*PIXEL_W +: PIXEL_W] = in_col[idx*PIXEL_W +: PIXEL_W];
    end
  end

  // Stage 1: register the reordered column and run the line FSM on each advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_q       <= '0;
      col_error_q  <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_restart_q <= 1'b0;
      s1_end_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_col_q     <= '0;
      s1_ocol_q    <= '0;
`ifdef BORDER_REPLICATE_EN
      fc_q         <= '0;
`endif
    end else if (adv) begin
      s1_vld_q     <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_restart_q <= 1'b0;
      s1_end_q     <= 1'b0;
      if (accept) begin
        prev_q    <= in_col_addr;
        s1_col_q  <= col_ord;
        s1_last_q <= in_line_last;
        s1_ocol_q <= in_col_addr - AW'(HALF);
        if (in_col_addr == '0) begin
          // Address 0 always starts a line; arriving mid-line it is also a sequence error
          col_error_q  <= col_error_q | (state_q != IDLE);
          s1_vld_q     <= 1'b1;
          s1_restart_q <= 1'b1;
          cnt_q        <= CW'(1);
          state_q      <= FILL;
        end else if (state_q == IDLE) begin
          // No line in progress: the beat is dropped
          col_error_q <= 1'b1;
        end else begin
          if (in_col_addr != prev_q + AW'(1)) col_error_q <= 1'b1;
          s1_vld_q <= 1'b1;
          if (cnt_q != CW'(WIN_SIZE - 1)) cnt_q <= cnt_q + CW'(1);
          if (state_q == FILL) begin
            // With replication, windows start once HALF real columns follow column 0
            s1_emit_q <= BORDER && (cnt_q >= CW'(HALF));
            if (cnt_q == CW'(WIN_SIZE - 2)) state_q <= STREAM;
          end else begin
            s1_emit_q <= 1'b1;
          end
          if (in_col_addr == AW'(IMAGE_WIDTH - 1)) begin
`ifdef BORDER_REPLICATE_EN
            state_q <= FLUSH;
            fc_q    <= '0;
`else
            state_q  <= IDLE;
            s1_end_q <= 1'b1;
`endif
          end
        end
      end
`ifdef BORDER_REPLICATE_EN
      else if (state_q == FLUSH) begin
        // Re-present the last column (still held in s1_col_q) to pad the right edge
        s1_vld_q  <= 1'b1;
        s1_emit_q <= 1'b1;
        s1_ocol_q <= s1_ocol_q + AW'(1);
        fc_q      <= fc_q + CW'(1);
        if (fc_q == CW'(HALF - 1)) begin
          s1_end_q <= 1'b1;
          state_q  <= IDLE;
        end
      end
`endif
    end
  end

  // Next window contents: shift in the newest column, or replicate column 0 at a line start
  always_comb begin
    win_d = win_q;
    if (BORDER && s1_restart_q) begin
      for (int c = 0; c < WIN_SIZE; c++) win_d[c] = s1_col_q;
    end else begin
      for (int c = 0; c < WIN_SIZE - 1; c++) win_d[c] = win_q[c+1];
      win_d[WIN_SIZE-1] = s1_col_q;
    end
  end

  // Flatten to element (r,c) ordering for the output bus
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN_SIZE; r++)
      for (int c = 0; c < WIN_SIZE; c++)
        win_flat[(r*WIN_SIZE+c)*PIXEL_W +: PIXEL_W] = win_d[c][r*PIXEL_W +: PIXEL_W];
  end

  // Stage 2: column shift register and registered window output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q           <= '0;
      out_valid_q     <= 1'b0;
      out_window_q    <= '0;
      out_col_q       <= '0;
      out_line_end_q  <= 1'b0;
      out_frame_end_q <= 1'b0;
    end else if (adv) begin
      out_valid_q     <= 1'b0;
      out_line_end_q  <= 1'b0;
      out_frame_end_q <= 1'b0;
      if (s1_vld_q) begin
        win_q <= win_d;
        if (s1_emit_q) begin
          out_valid_q     <= 1'b1;
          out_window_q    <= win_flat;
          out_col_q       <= s1_ocol_q;
          out_line_end_q  <= s1_end_q;
          out_frame_end_q <= s1_end_q && s1_last_q;
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_window    = out_window_q;
  assign out_col       = out_col_q;
  assign out_line_end  = out_line_end_q;
  assign out_frame_end = out_frame_end_q;
  assign frame_done    = out_valid_q && out_ready && out_frame_end_q;
  assign col_error     = col_error_q;

endmodule
